// File: rtl/ntlm_md4_driver_if.sv
// Request/result side and md4block handshake of ntlm_md4_driver, bundled as one interface.
// The slave modport is the driver's view; master is the view of its surroundings.
interface ntlm_md4_driver_if;
    logic         start;
    logic [4:0]   pw_len;
    logic [215:0] pw_data;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] hash;

    logic         md4_irdy;
    logic [31:0]  md4_state_a;
    logic [31:0]  md4_state_b;
    logic [31:0]  md4_state_c;
    logic [31:0]  md4_state_d;
    logic [511:0] md4_data;
    logic         md4_ordy;
    logic [31:0]  md4_newstate_a;
    logic [31:0]  md4_newstate_b;
    logic [31:0]  md4_newstate_c;
    logic [31:0]  md4_newstate_d;

    modport slave (
        input  start, pw_len, pw_data, md4_ordy,
               md4_newstate_a, md4_newstate_b, md4_newstate_c, md4_newstate_d,
        output busy, done, err, hash, md4_irdy,
               md4_state_a, md4_state_b, md4_state_c, md4_state_d, md4_data
    );

    modport master (
        output start, pw_len, pw_data, md4_ordy,
               md4_newstate_a, md4_newstate_b, md4_newstate_c, md4_newstate_d,
        input  busy, done, err, hash, md4_irdy,
               md4_state_a, md4_state_b, md4_state_c, md4_state_d, md4_data
    );
endinterface

// File: rtl/ntlm_md4_driver.sv
// NTLM front end: expands an ASCII candidate to UTF-16LE, builds the padded MD4 block,
// drives md4block through irdy/ordy and presents the digest in canonical byte order.
module ntlm_md4_driver #(
    parameter int unsigned MAX_CHARS = 27
) (
    input logic              clk,
    input logic              reset,
    ntlm_md4_driver_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StBuild,
        StPad,
        StGo1,
        StGo2,
        StWait,
        StFin
    } state_e;

    state_e       state_q, state_d;
    logic [4:0]   len_q, len_d;
    logic [4:0]   idx_q, idx_d;
    logic [215:0] pw_q, pw_d;
    logic [511:0] data_q, data_d;
    logic [31:0]  sa_q, sa_d;
    logic [31:0]  sb_q, sb_d;
    logic [31:0]  sc_q, sc_d;
    logic [31:0]  sd_q, sd_d;
    logic [127:0] hash_q, hash_d;
    logic         err_q, err_d;

    // Bit offsets: each UTF-16 char occupies 16 block bits, each ASCII char 8 input bits.
    // len_pos doubles as the message bit length L = 16 * len.
    logic [8:0]   char_pos;
    logic [8:0]   len_pos;
    logic [7:0]   pw_pos;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign char_pos = {idx_q, 4'b0000};
    assign len_pos  = {len_q, 4'b0000};
    assign pw_pos   = {idx_q, 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
            pw_q    <= '0;
            data_q  <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            sc_q    <= '0;
            sd_q    <= '0;
            hash_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            pw_q    <= pw_d;
            data_q  <= data_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sc_q    <= sc_d;
            sd_q    <= sd_d;
            hash_q  <= hash_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        pw_d    = pw_q;
        data_d  = data_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sc_d    = sc_q;
        sd_d    = sd_q;
        hash_d  = hash_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    len_d   = bus.pw_len;
                    pw_d    = bus.pw_data;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if ({27'b0, len_q} > MAX_CHARS) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    data_d  = '0;
                    idx_d   = '0;
                    state_d = (len_q == 5'd0) ? StPad : StBuild;
                end
            end
            StBuild: begin
                data_d[9'd511 - char_pos -: 8] = pw_q[8'd215 - pw_pos -: 8];
                data_d[9'd503 - char_pos -: 8] = 8'h00;
                idx_d = idx_q + 5'd1;
                if (idx_q == len_q - 5'd1) begin
                    state_d = StPad;
                end
            end
            StPad: begin
                data_d[9'd511 - len_pos -: 8] = 8'h80;
                data_d[63:56] = len_pos[7:0];
                data_d[55:48] = {7'b0, len_pos[8]};
                sa_d    = 32'h67452301;
                sb_d    = 32'hEFCDAB89;
                sc_d    = 32'h98BADCFE;
                sd_d    = 32'h10325476;
                state_d = StGo1;
            end
            StGo1: begin
                state_d = StGo2;
            end
            StGo2: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.md4_ordy) begin
                    hash_d  = {bswap32(bus.md4_newstate_a), bswap32(bus.md4_newstate_b),
                               bswap32(bus.md4_newstate_c), bswap32(bus.md4_newstate_d)};
                    err_d   = 1'b0;
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Decoded from the state register so irdy falls asynchronously with reset.
    assign bus.md4_irdy    = (state_q == StGo1) || (state_q == StGo2);
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StFin);
    assign bus.err         = err_q;
    assign bus.hash        = hash_q;
    assign bus.md4_data    = data_q;
    assign bus.md4_state_a = sa_q;
    assign bus.md4_state_b = sb_q;
    assign bus.md4_state_c = sc_q;
    assign bus.md4_state_d = sd_q;

endmodule

// File: tb/tb_ntlm_md4_driver.sv
// Bench for ntlm_md4_driver: behavioural md4block responder, scoreboard of expected
// completions, and directed jobs around the length limits, handshake and reset.
module tb_ntlm_md4_driver;

    localparam logic [127:0] IV         = {32'h67452301, 32'hEFCDAB89,
                                           32'h98BADCFE, 32'h10325476};
    localparam logic [127:0] HASH_EMPTY = 128'h31D6CFE0D16AE931B73C59D7E0C089C0;
    localparam logic [127:0] HASH_PASSW = 128'h8846F7EAEE8FB117AD06BDD830B7586C;
    localparam logic [127:0] HASH_TEST  = 128'h0CB6948805F797BF2A82807973B89537;

    typedef struct {
        logic         err;
        logic [127:0] hash;
        logic [511:0] blk;
        int           done_cyc;
        int           irdy_n;
        bit           known;
        logic [127:0] known_hash;
    } exp_t;

    exp_t         sb[$];
    logic         clk = 1'b0;
    logic         reset;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           ordy_delay = 0;
    int           irdy_cnt = 0;
    logic [511:0] cap_data = '0;
    logic [127:0] cap_iv = '0;
    logic [127:0] last_hash = '0;

    ntlm_md4_driver_if bus_if ();

    ntlm_md4_driver #(
        .MAX_CHARS(27)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Reference MD4 compression of one block, chaining values added back in.
    function automatic logic [127:0] md4(input logic [127:0] iv, input logic [511:0] blk);
        logic [31:0] x [16];
        logic [31:0] v [4];
        logic [31:0] y, z, w, f, t, kc;
        logic [3:0]  r4;
        int          ti, k, s, r;
        for (int j = 0; j < 16; j++) begin
            x[j] = {blk[511-8*(4*j+3) -: 8], blk[511-8*(4*j+2) -: 8],
                    blk[511-8*(4*j+1) -: 8], blk[511-8*(4*j) -: 8]};
        end
        v[0] = iv[127:96]; v[1] = iv[95:64]; v[2] = iv[63:32]; v[3] = iv[31:0];
        for (int i = 0; i < 48; i++) begin
            ti = (4 - (i % 4)) % 4;
            y  = v[(ti + 1) % 4];
            z  = v[(ti + 2) % 4];
            w  = v[(ti + 3) % 4];
            r  = i % 16;
            if (i < 16) begin
                f = (y & z) | (~y & w); k = r; kc = 32'h0;
                case (i % 4) 0: s = 3; 1: s = 7; 2: s = 11; default: s = 19; endcase
            end else if (i < 32) begin
                f = (y & z) | (y & w) | (z & w); k = (r % 4) * 4 + r / 4; kc = 32'h5A827999;
                case (i % 4) 0: s = 3; 1: s = 5; 2: s = 9; default: s = 13; endcase
            end else begin
                r4 = 4'(r);
                f = y ^ z ^ w; k = int'({r4[0], r4[1], r4[2], r4[3]}); kc = 32'h6ED9EBA1;
                case (i % 4) 0: s = 3; 1: s = 9; 2: s = 11; default: s = 15; endcase
            end
            t = v[ti] + f + x[k] + kc;
            v[ti] = (t << s) | (t >> (32 - s));
        end
        return {v[0] + iv[127:96], v[1] + iv[95:64], v[2] + iv[63:32], v[3] + iv[31:0]};
    endfunction

    function automatic logic [511:0] build_block(input int len, input logic [215:0] pw);
        logic [511:0] b;
        logic [8:0]   l;
        b = '0;
        for (int i = 0; i < len; i++) b[511-16*i -: 8] = pw[215-8*i -: 8];
        b[511-16*len -: 8] = 8'h80;
        l = 9'(16 * len);
        b[63:56] = l[7:0];
        b[48]    = l[8];
        return b;
    endfunction

    function automatic logic [127:0] ntlm_of(input logic [511:0] blk);
        logic [127:0] r;
        r = md4(IV, blk);
        return {bswap(r[127:96]), bswap(r[95:64]), bswap(r[63:32]), bswap(r[31:0])};
    endfunction

    // Bytes beyond the string are random: they are don't-care for the DUT.
    function automatic logic [215:0] make_pw(input string s);
        logic [215:0] p;
        for (int i = 0; i < 27; i++) p[215-8*i -: 8] = 8'($urandom);
        for (int i = 0; i < s.len(); i++) p[215-8*i -: 8] = s[i];
        return p;
    endfunction

    task automatic push_exp(input int len, input logic [215:0] pw, input int c, input int dly,
                            input bit known, input logic [127:0] kh);
        exp_t e;
        e.known      = known;
        e.known_hash = kh;
        if (len > 27) begin
            e.err      = 1'b1;
            e.hash     = last_hash;
            e.blk      = '0;
            e.done_cyc = c + 2;
            e.irdy_n   = 0;
        end else begin
            e.err      = 1'b0;
            e.blk      = build_block(len, pw);
            e.hash     = ntlm_of(e.blk);
            last_hash  = e.hash;
            e.done_cyc = c + len + 5 + dly + 1;
            e.irdy_n   = 2;
        end
        sb.push_back(e);
    endtask

    // Called at a negedge while idle; c is the cycle-0 reference for latency checks.
    task automatic start_job(input int len, input logic [215:0] pw, input int dly,
                             input bit known, input logic [127:0] kh, input bit hold,
                             output int c);
        ordy_delay = dly;
        c = cyc;
        push_exp(len, pw, c, dly, known, kh);
        bus_if.pw_len  = 5'(len);
        bus_if.pw_data = pw;
        bus_if.start   = 1'b1;
        @(negedge clk);
        if (!hold) begin
            bus_if.start   = 1'b0;
            bus_if.pw_len  = 5'($urandom);
            bus_if.pw_data = make_pw("");
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 512'(sb.size()), 512'(0));
            sb.delete();
        end
        repeat (3) @(negedge clk);
        check("idle_busy", 512'(bus_if.busy), 512'(0));
    endtask

    // md4block stand-in: answers ordy_delay+1 cycles into WAIT with the real MD4 result.
    initial begin
        logic         prev_irdy;
        bit           pending;
        int           wait_cnt;
        logic [127:0] r;
        prev_irdy = 1'b0;
        pending   = 1'b0;
        wait_cnt  = 0;
        bus_if.md4_ordy       = 1'b0;
        bus_if.md4_newstate_a = '0;
        bus_if.md4_newstate_b = '0;
        bus_if.md4_newstate_c = '0;
        bus_if.md4_newstate_d = '0;
        forever begin
            @(negedge clk);
            bus_if.md4_ordy = 1'b0;
            if (reset) begin
                prev_irdy = 1'b0;
                pending   = 1'b0;
            end else begin
                if (bus_if.md4_irdy) begin
                    irdy_cnt++;
                    cap_data = bus_if.md4_data;
                    cap_iv   = {bus_if.md4_state_a, bus_if.md4_state_b,
                                bus_if.md4_state_c, bus_if.md4_state_d};
                end
                if (prev_irdy && !bus_if.md4_irdy) begin
                    pending  = 1'b1;
                    wait_cnt = ordy_delay;
                end
                if (pending) begin
                    if (wait_cnt == 0) begin
                        r = md4(cap_iv, cap_data);
                        bus_if.md4_newstate_a = r[127:96];
                        bus_if.md4_newstate_b = r[95:64];
                        bus_if.md4_newstate_c = r[63:32];
                        bus_if.md4_newstate_d = r[31:0];
                        bus_if.md4_ordy = 1'b1;
                        pending = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
                prev_irdy = bus_if.md4_irdy;
            end
        end
    end

    // Completion monitor: every done pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_if.done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 512'(bus_if.done), 512'(0));
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", 512'(cyc), 512'(e.done_cyc));
                    check("busy_at_done", 512'(bus_if.busy), 512'(1));
                    check("err", 512'(bus_if.err), 512'(e.err));
                    check("hash", 512'(bus_if.hash), 512'(e.hash));
                    if (e.known) check("hash_known", 512'(bus_if.hash), 512'(e.known_hash));
                    check("irdy_cycles", 512'(irdy_cnt), 512'(e.irdy_n));
                    if (!e.err) begin
                        check("md4_block", cap_data, e.blk);
                        check("md4_iv", 512'(cap_iv), 512'(IV));
                    end
                    irdy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           c;
        int           n;
        logic [215:0] pw;
        logic [511:0] t;

        reset          = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.pw_len  = '0;
        bus_if.pw_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 512'(bus_if.busy), 512'(0));
        check("rst_done", 512'(bus_if.done), 512'(0));
        check("rst_err", 512'(bus_if.err), 512'(0));
        check("rst_hash", 512'(bus_if.hash), 512'(0));
        check("rst_irdy", 512'(bus_if.md4_irdy), 512'(0));
        check("rst_data", bus_if.md4_data, 512'(0));
        check("rst_state", 512'({bus_if.md4_state_a, bus_if.md4_state_b,
                                 bus_if.md4_state_c, bus_if.md4_state_d}), 512'(0));
        reset = 1'b0;
        @(negedge clk);

        // Empty password
        start_job(0, make_pw(""), 0, 1'b1, HASH_EMPTY, 1'b0, c);
        drain(100);
        t = '0;
        t[511:504] = 8'h80;
        check("empty_block", cap_data, t);

        // "password"
        start_job(8, make_pw("password"), 2, 1'b1, HASH_PASSW, 1'b0, c);
        drain(100);
        check("password_len_field", 512'(cap_data[63:48]), 512'(16'h8000));

        // "test" then empty, start held through FIN
        start_job(4, make_pw("test"), 1, 1'b1, HASH_TEST, 1'b1, c);
        bus_if.pw_len  = 5'd0;
        bus_if.pw_data = make_pw("");
        push_exp(0, bus_if.pw_data, c + 4 + 5 + 2 + 1, 1, 1'b1, HASH_EMPTY);
        n = 0;
        while (!bus_if.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done", 512'(bus_if.done), 512'(1));
        @(negedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        drain(100);

        // Longest accepted length
        pw = make_pw("");
        for (int i = 0; i < 27; i++) pw[215-8*i -: 8] = 8'h41;
        start_job(27, pw, 1, 1'b0, '0, 1'b0, c);
        drain(100);
        check("max_pad_byte", 512'(cap_data[79:72]), 512'(8'h80));
        check("max_len_field", 512'(cap_data[63:48]), 512'(16'hB001));

        // Rejected lengths: hash must be unchanged
        start_job(28, make_pw("abcd"), 0, 1'b0, '0, 1'b0, c);
        drain(20);
        start_job(31, make_pw("abcd"), 0, 1'b0, '0, 1'b0, c);
        drain(20);

        // Held-off ordy with a stray start mid-job
        start_job(3, make_pw("abc"), 39, 1'b0, '0, 1'b0, c);
        repeat (19) @(negedge clk);
        check("holdoff_busy", 512'(bus_if.busy), 512'(1));
        bus_if.start  = 1'b1;
        bus_if.pw_len = 5'd5;
        @(negedge clk);
        bus_if.start  = 1'b0;
        drain(100);
        repeat (60) @(negedge clk);

        // Reset during GO2
        start_job(4, make_pw("test"), 0, 1'b0, '0, 1'b0, c);
        n = 0;
        while (cyc < c + 4 + 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("go2_irdy", 512'(bus_if.md4_irdy), 512'(1));
        reset = 1'b1;
        #1;
        check("abort_irdy", 512'(bus_if.md4_irdy), 512'(0));
        check("abort_busy", 512'(bus_if.busy), 512'(0));
        check("abort_done", 512'(bus_if.done), 512'(0));
        check("abort_err", 512'(bus_if.err), 512'(0));
        check("abort_hash", 512'(bus_if.hash), 512'(0));
        check("abort_data", bus_if.md4_data, 512'(0));
        check("abort_state", 512'({bus_if.md4_state_a, bus_if.md4_state_b,
                                   bus_if.md4_state_c, bus_if.md4_state_d}), 512'(0));
        sb.delete();
        last_hash = '0;
        repeat (3) @(negedge clk);
        irdy_cnt = 0;
        reset = 1'b0;
        repeat (30) @(negedge clk);

        // Fresh job after reset
        start_job(8, make_pw("password"), 5, 1'b1, HASH_PASSW, 1'b0, c);
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
